// File: rtl/core_oam_dma_if.sv
// Bus bundle between the CPU core, the system bus and the OAM DMA engine.
// The DMA engine sits on the slave side; the core/bus environment sits on the master side.
interface core_oam_dma_if;
    logic        I_cycle;
    logic [15:0] I_cpu_addr;
    logic [7:0]  I_cpu_wr_data;
    logic        I_cpu_rdwr;
    logic [7:0]  I_rd_data;
    logic [15:0] O_addr;
    logic [7:0]  O_wr_data;
    logic        O_rdwr;
    logic        O_active;
    logic        O_ready;

    modport slave (
        input  I_cycle, I_cpu_addr, I_cpu_wr_data, I_cpu_rdwr, I_rd_data,
        output O_addr, O_wr_data, O_rdwr, O_active, O_ready
    );

    modport master (
        output I_cycle, I_cpu_addr, I_cpu_wr_data, I_cpu_rdwr, I_rd_data,
        input  O_addr, O_wr_data, O_rdwr, O_active, O_ready
    );
endinterface

// File: rtl/core_oam_dma.sv
// OAM DMA engine: a core write to 16'h4014 stalls the core and copies page {P,00..FF} to 16'h2004.
// Define CORE_OAM_DMA_ALIGN_EN to add the odd-cycle ALIGN dummy read driven by the bus parity bit.
//
// state | meaning
// IDLE  | core owns the bus, O_ready=1, waiting for a write to 16'h4014
// HALT  | core stalled, one cycle for it to finish its current bus cycle
// ALIGN | dummy read at {page,counter} to reach an even cycle (data discarded)
// READ  | read {page,counter} into the data register
// WRITE | write data register to 16'h2004, advance counter
module core_oam_dma (
    input  logic          I_clock,
    input  logic          I_reset,
    core_oam_dma_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] page, page_nxt;
    logic [7:0] count, count_nxt;
    logic [7:0] data, data_nxt;
    logic       ready;
    logic       parity;
    logic       trigger;

    assign trigger = (bus.I_cpu_addr == 16'h4014) && !bus.I_cpu_rdwr;

`ifdef CORE_OAM_DMA_ALIGN_EN
    // Tracks even/odd CPU cycles from reset so the transfer can start on a read-friendly cycle.
    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            parity <= 1'b0;
        end else if (bus.I_cycle) begin
            parity <= ~parity;
        end
    end
`else
    assign parity = 1'b0;
`endif

    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            state <= S_IDLE;
            page  <= 8'h00;
            count <= 8'h00;
            data  <= 8'h00;
            ready <= 1'b1;
        end else begin
            state <= state_nxt;
            page  <= page_nxt;
            count <= count_nxt;
            data  <= data_nxt;
            ready <= (state_nxt == S_IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        page_nxt  = page;
        count_nxt = count;
        data_nxt  = data;
        if (bus.I_cycle) begin
            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        state_nxt = S_HALT;
                        page_nxt  = bus.I_cpu_wr_data;
                        count_nxt = 8'h00;
                    end
                end
                S_HALT:  state_nxt = parity ? S_ALIGN : S_READ;
                S_ALIGN: state_nxt = S_READ;
                S_READ: begin
                    data_nxt  = bus.I_rd_data;
                    state_nxt = S_WRITE;
                end
                S_WRITE: begin
                    count_nxt = count + 8'd1;
                    state_nxt = (count == 8'hFF) ? S_IDLE : S_READ;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Page and counter are concatenated, so page FF never carries past FFFF.
    always_comb begin
        bus.O_active  = 1'b0;
        bus.O_rdwr    = 1'b1;
        bus.O_addr    = 16'h0000;
        bus.O_wr_data = 8'h00;
        case (state)
            S_ALIGN, S_READ: begin
                bus.O_active = 1'b1;
                bus.O_addr   = {page, count};
            end
            S_WRITE: begin
                bus.O_active  = 1'b1;
                bus.O_rdwr    = 1'b0;
                bus.O_addr    = 16'h2004;
                bus.O_wr_data = data;
            end
            default: ;
        endcase
    end

    assign bus.O_ready = ready;
endmodule

// File: tb/tb_core_oam_dma.sv
// Scoreboard bench for core_oam_dma: the driver pushes expected bus cycles and stall lengths,
// a monitor compares every DMA bus cycle and stall against them; a memory array answers reads.
module tb_core_oam_dma;
`ifdef CORE_OAM_DMA_ALIGN_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] addr;
        logic        rdwr;
        logic [7:0]  data;
    } xact_t;

    logic clk = 1'b0;
    logic rst_b;

    core_oam_dma_if bus();

    core_oam_dma dut (
        .I_clock(clk),
        .I_reset(rst_b),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [65536];
    assign bus.I_rd_data = mem[bus.O_addr];

    xact_t exp_q[$];
    int    stall_q[$];
    int    n_checks    = 0;
    int    n_fail      = 0;
    int    pulse_cnt   = 0;
    int    writes_seen = 0;
    int    stall_cnt   = 0;
    xact_t mon_e;
    int    mon_stall;

    // Monitor: samples 2 time units after each falling edge, well clear of the rising edge.
    always @(negedge clk) begin
        #2;
        if (rst_b === 1'b0) stall_cnt = 0;
        if (rst_b === 1'b0 || (exp_q.size() == 0 && stall_q.size() == 0 && stall_cnt == 0)) begin
            n_checks++;
            if (bus.O_ready !== 1'b1 || bus.O_active !== 1'b0 || bus.O_addr !== 16'h0000 ||
                bus.O_rdwr !== 1'b1 || bus.O_wr_data !== 8'h00) begin
                n_fail++;
                $display("FAIL idle_outputs: got ready=%b active=%b addr=%h rdwr=%b wdata=%h, need 1 0 0000 1 00",
                         bus.O_ready, bus.O_active, bus.O_addr, bus.O_rdwr, bus.O_wr_data);
            end
        end
        if (bus.O_active === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_bus: got addr=%h rdwr=%b, need no DMA cycle", bus.O_addr, bus.O_rdwr);
            end else begin
                mon_e = exp_q[0];
                if (bus.O_addr !== mon_e.addr || bus.O_rdwr !== mon_e.rdwr ||
                    (mon_e.rdwr == 1'b0 && bus.O_wr_data !== mon_e.data)) begin
                    n_fail++;
                    $display("FAIL bus_cycle: got addr=%h rdwr=%b wdata=%h, need addr=%h rdwr=%b wdata=%h",
                             bus.O_addr, bus.O_rdwr, bus.O_wr_data, mon_e.addr, mon_e.rdwr, mon_e.data);
                end
                if (bus.I_cycle === 1'b1) begin
                    void'(exp_q.pop_front());
                    if (mon_e.rdwr == 1'b0) writes_seen++;
                end
            end
        end
        if (rst_b === 1'b1 && bus.I_cycle === 1'b1) begin
            if (bus.O_ready === 1'b0) begin
                stall_cnt++;
            end else if (stall_cnt > 0) begin
                n_checks++;
                if (stall_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stall_unexpected: got %0d stalled cycles, need none", stall_cnt);
                end else begin
                    mon_stall = stall_q.pop_front();
                    if (stall_cnt != mon_stall) begin
                        n_fail++;
                        $display("FAIL stall_length: got %0d cycles, need %0d", stall_cnt, mon_stall);
                    end
                end
                stall_cnt = 0;
            end
        end
    end

    task automatic pulse(input int gap);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.I_cycle = 1'b1;
        pulse_cnt++;
        @(negedge clk);
        bus.I_cycle = 1'b0;
    endtask

    task automatic idle_cycle();
        bus.I_cpu_addr    = 16'($urandom);
        bus.I_cpu_wr_data = 8'($urandom);
        bus.I_cpu_rdwr    = 1'b1;
        pulse($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_b = 1'b0;
        exp_q.delete();
        stall_q.delete();
        pulse_cnt = 0;
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
    endtask

    // want_par: -1 any, else force the parity seen at the HALT-ending cycle.
    task automatic run_transfer(input logic [7:0] page, input int want_par, input int abort_after,
                                input int hold_at);
        xact_t e;
        int    align;
        int    wbase;
        int    n_pulses;
        bit    held;
        if (want_par >= 0 && ((pulse_cnt + 1) % 2) != want_par) idle_cycle();
        // Parity before a pulse equals the number of earlier pulses since reset, mod 2.
        align = (ALIGN_EN && ((pulse_cnt + 1) % 2 == 1)) ? 1 : 0;
        if (align == 1) begin
            e.addr = {page, 8'h00}; e.rdwr = 1'b1; e.data = 8'h00;
            exp_q.push_back(e);
        end
        for (int n = 0; n < 256; n++) begin
            e.addr = {page, 8'(n)}; e.rdwr = 1'b1; e.data = 8'h00;
            exp_q.push_back(e);
            e.addr = 16'h2004; e.rdwr = 1'b0; e.data = mem[{page, 8'(n)}];
            exp_q.push_back(e);
        end
        stall_q.push_back(513 + align);
        wbase = writes_seen;
        bus.I_cpu_addr    = 16'h4014;
        bus.I_cpu_rdwr    = 1'b0;
        bus.I_cpu_wr_data = page;
        pulse($urandom_range(0, 1));
        n_pulses = 0;
        held = 1'b0;
        while (exp_q.size() > 0 && n_pulses < 700) begin
            if (abort_after > 0 && (writes_seen - wbase) >= abort_after) break;
            // Stalled-core bus noise, including retriggers that must be ignored.
            if ($urandom_range(0, 3) == 0) begin
                bus.I_cpu_addr = 16'h4014;
                bus.I_cpu_rdwr = 1'b0;
            end else begin
                bus.I_cpu_addr = 16'($urandom);
                bus.I_cpu_rdwr = 1'($urandom);
            end
            bus.I_cpu_wr_data = 8'($urandom);
            if (!held && hold_at >= 0 && n_pulses >= hold_at && exp_q.size() > 0 && exp_q[0].rdwr) begin
                held = 1'b1;
                pulse(20);
            end else begin
                pulse($urandom_range(0, 1));
            end
            n_pulses++;
        end
        if (abort_after > 0) begin
            n_checks++;
            if ((writes_seen - wbase) != abort_after) begin
                n_fail++;
                $display("FAIL abort_point: got %0d writes before reset, need %0d", writes_seen - wbase, abort_after);
            end
            do_reset();
        end else begin
            n_checks++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL transfer_timeout: got %0d cycles outstanding, need 0", exp_q.size());
                do_reset();
            end
        end
        repeat (3) idle_cycle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish by time limit, need finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int n = 0; n < 256; n++) mem[16'hFF00 + n] = 8'(n) ^ 8'h5A;
        rst_b             = 1'b0;
        bus.I_cycle       = 1'b0;
        bus.I_cpu_addr    = 16'h0000;
        bus.I_cpu_wr_data = 8'h00;
        bus.I_cpu_rdwr    = 1'b1;
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        repeat (4) idle_cycle();

        // Accesses that must not start a transfer.
        bus.I_cpu_addr = 16'h4014; bus.I_cpu_rdwr = 1'b1; bus.I_cpu_wr_data = 8'h02;
        pulse(0);
        bus.I_cpu_addr = 16'h4015; bus.I_cpu_rdwr = 1'b0; bus.I_cpu_wr_data = 8'h02;
        pulse(1);
        bus.I_cpu_addr = 16'h4014; bus.I_cpu_rdwr = 1'b1;
        pulse(0);
        repeat (2) idle_cycle();

        run_transfer(8'h02, 0, 0, -1);
        run_transfer(8'h02, 1, 0, 41);
        run_transfer(8'hFF, -1, 0, -1);
        run_transfer(8'($urandom), -1, 100, -1);
        repeat (6) idle_cycle();
        run_transfer(8'($urandom), -1, 0, 7);

        n_checks++;
        if (exp_q.size() != 0 || stall_q.size() != 0) begin
            n_fail++;
            $display("FAIL final_drain: got %0d bus and %0d stall entries left, need 0 0", exp_q.size(), stall_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/core_oam_dma.md
CORE_OAM_DMA -- requirements
Module: core_oam_dma

Interface
REQ-001 SHALL have port I_clock  input  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have port I_reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port I_cycle  input  1  one-clock pulse marking the end of each CPU bus cycle (phi2 falling edge); independent of ready.
REQ-004 SHALL have port I_cpu_addr  input  16  address driven by the core.
REQ-005 SHALL have port I_cpu_wr_data  input  8  write data driven by the core.
REQ-006 SHALL have port I_cpu_rdwr  input  1  core bus direction; 1=read, 0=write.
REQ-007 SHALL have port I_rd_data  input  8  data returned by the bus.
REQ-008 SHALL have port O_addr  output  16  DMA bus address.
REQ-009 SHALL have port O_wr_data  output  8  DMA write data.
REQ-010 SHALL have port O_rdwr  output  1  DMA bus direction; 1=read.
REQ-011 SHALL have port O_active  output  1  1 = DMA owns the bus; external mux selects O_addr/O_wr_data/O_rdwr over the core's.
REQ-012 SHALL have port O_ready  output  1  to core I_ready; 0 stalls the core.

Function
REQ-013 States SHALL be IDLE, HALT, ALIGN, READ, WRITE; transitions occur only on clocks where I_cycle=1.
REQ-014 IDLE->HALT when I_cycle=1, I_cpu_rdwr=0 and I_cpu_addr=16'h4014; page register latches I_cpu_wr_data; byte counter cleared to 0.
REQ-015 O_ready SHALL be 0 in every state except IDLE, registered, so it falls on the clock after the triggering I_cycle.
REQ-016 HALT SHALL last exactly one CPU cycle; O_active=0 during HALT, letting the stalled core finish its bus cycle.
REQ-017 A parity bit SHALL toggle on every I_cycle pulse in all states; HALT->ALIGN if parity=1 at the HALT-ending pulse, else HALT->READ.
REQ-018 ALIGN SHALL last one cycle: O_active=1, O_rdwr=1, O_addr={page,counter}; read data discarded; ALIGN->READ.
REQ-019 READ: O_active=1, O_rdwr=1, O_addr={page,counter}; I_rd_data captured into data register at the ending I_cycle; READ->WRITE.
REQ-020 WRITE: O_active=1, O_rdwr=0, O_addr=16'h2004, O_wr_data=data register; at ending I_cycle counter increments (8-bit, wraps).
REQ-021 WRITE->READ if the counter was below 8'hFF before increment; WRITE->IDLE if it was 8'hFF (256 bytes transferred).
REQ-022 Total stall SHALL be 513 cycles with parity=0 and 514 with parity=1 (HALT + optional ALIGN + 512).
REQ-023 Writes to 16'h4014 while not IDLE SHALL be ignored; the core cannot issue them while stalled.
REQ-024 Page 8'hFF SHALL read 16'hFF00..16'hFFFF without address carry into bit 16.
REQ-025 In IDLE: O_active=0, O_rdwr=1, O_addr=16'h0000, O_wr_data=8'h00, O_ready=1.
REQ-026 With I_cycle=0, all state, counter, page, data and outputs SHALL hold.

Reset
REQ-027 I_reset=0 SHALL asynchronously force IDLE, page=8'h00, counter=8'h00, data=8'h00, parity=0, and the REQ-025 output values.
REQ-028 Reset asserted mid-transfer SHALL abort it; no further bus cycles are issued, and no transfer resumes after reset deasserts.

Configuration
REQ-029 Macro CORE_OAM_DMA_ALIGN_EN defined SHALL compile in the parity bit and ALIGN state per REQ-017/018.
REQ-030 Without CORE_OAM_DMA_ALIGN_EN, HALT SHALL always go to READ, and every transfer stalls exactly 513 cycles.

Verification
REQ-031 Parity=0, core writes 8'h02 to 16'h4014 -> O_ready low 513 cycles; reads 16'h0200..16'h02FF, each followed by a write to 16'h2004 with the read byte.
REQ-032 Parity=1, same trigger (macro defined) -> one ALIGN read at 16'h0200, then 512 transfer cycles; total stall 514.
REQ-033 Page 8'hFF, memory byte n = n XOR 8'h5A -> 256 writes to 16'h2004 carry FF00..FFFF contents in order; last address 16'hFFFF, then IDLE.
REQ-034 Core read of 16'h4014, or write to 16'h4015 -> no state change; O_ready stays 1.
REQ-035 I_reset pulsed low after 100 bytes -> immediate IDLE outputs, O_ready=1; no bus activity after I_reset returns high.
REQ-036 I_cycle held low for 20 clocks mid-READ -> O_addr, O_rdwr and counter unchanged until the next pulse.
